gpio_irq_ctrl: RTL and testbench

GPIO_IRQ_CTRL -- requirements
Module: gpio_irq_ctrl

---
 rtl/gpio_irq_ctrl_pkg.sv | 10 +
 rtl/debounce_cell.sv | 67 ++++++
 rtl/gpio_irq_defs.svh | 16 +
 rtl/synchronizer.sv | 34 +++
 rtl/gpio_irq_ctrl.sv | 135 +++++++++++++
 tb/tb_gpio_irq_ctrl.sv | 258 +++++++++++++++++++++++++
 6 files changed

// File: rtl/gpio_irq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// gpio_irq_ctrl_pkg
// Package wrapper around the shared register address definitions, so the
// controller and its helpers can pull them in with a single import.
// ---------------------------------------------------------------------------
package gpio_irq_ctrl_pkg;

  `include "gpio_irq_defs.svh"

endpackage

// File: rtl/debounce_cell.sv
// ---------------------------------------------------------------------------
// debounce_cell
// Single-pin debouncer. A new synchronized level must be seen for
// DEBOUNCE_CYCLES consecutive cycles before it becomes the stable level v;
// at that moment a one-cycle rise or fall pulse is produced.
//
// Ports:
//   clk_i  : clock
//   rstn_i : synchronous active-low reset (clears v and the counter)
//   s_i    : synchronized pin level
//   v_o    : debounced stable level
//   rise_o : one-cycle pulse, same cycle v is about to change 0 -> 1
//   fall_o : one-cycle pulse, same cycle v is about to change 1 -> 0
// ---------------------------------------------------------------------------
module debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic s_i,
  output logic v_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          v_q, v_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fire;

  // The counter tracks how long s has disagreed with v. Any agreement resets
  // it, so only an uninterrupted run of DEBOUNCE_CYCLES disagreeing samples
  // can flip v. The pulses are combinational so the caller can register an
  // event on the same edge that updates v.
  always_comb begin
    v_d   = v_q;
    cnt_d = cnt_q;
    fire  = 1'b0;
    if (s_i == v_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      v_d   = s_i;
      cnt_d = '0;
      fire  = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Reset drops any count in progress, so debouncing always starts fresh.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      v_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      v_q   <= v_d;
      cnt_q <= cnt_d;
    end
  end

  assign v_o    = v_q;
  assign rise_o = fire & s_i;
  assign fall_o = fire & ~s_i;

endmodule

// File: rtl/gpio_irq_defs.svh
// ---------------------------------------------------------------------------
// gpio_irq_defs.svh
// Shared register word addresses for the GPIO interrupt controller. Any block
// or software-facing model that decodes the register map includes this file,
// so all of them agree on where each register lives.
// ---------------------------------------------------------------------------
`ifndef GPIO_IRQ_DEFS_SVH
`define GPIO_IRQ_DEFS_SVH

localparam logic [2:0] ADDR_STATE   = 3'd0;
localparam logic [2:0] ADDR_IRQ_EN  = 3'd1;
localparam logic [2:0] ADDR_PENDING = 3'd2;
localparam logic [2:0] ADDR_RISE_EN = 3'd3;
localparam logic [2:0] ADDR_FALL_EN = 3'd4;

`endif

// File: rtl/synchronizer.sv
// ---------------------------------------------------------------------------
// synchronizer
// Multi-bit, multi-stage flip-flop synchronizer for bringing asynchronous
// levels into the clk domain. Each bit is synchronized independently.
//
// Ports:
//   clk_i : destination clock
//   d_i   : asynchronous input levels, LEN bits
//   q_o   : synchronized levels, STAGES clock edges later
// ---------------------------------------------------------------------------
module synchronizer #(
  parameter int LEN    = 1,
  parameter int STAGES = 2
) (
  input  logic           clk_i,
  input  logic [LEN-1:0] d_i,
  output logic [LEN-1:0] q_o
);

  logic [LEN-1:0] stage_q [STAGES];

  // Plain shift chain with no reset: the first stage may go metastable, and a
  // reset term here would only add logic in front of that flop while the
  // chain flushes itself within STAGES cycles anyway.
  always_ff @(posedge clk_i) begin
    stage_q[0] <= d_i;
    for (int k = 1; k < STAGES; k++) begin
      stage_q[k] <= stage_q[k-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/gpio_irq_ctrl.sv
// ---------------------------------------------------------------------------
// gpio_irq_ctrl
// GPIO input block with per-pin synchronization, debouncing and edge
// interrupts, plus a small register interface.
//
// Register map (word addresses):
//   0 STATE   RO   debounced pin levels
//   1 IRQ_EN  RW   interrupt enable per pin
//   2 PENDING RO   latched edge events, write 1 to clear
//   3 RISE_EN RW   rising edges set PENDING
//   4 FALL_EN RW   falling edges set PENDING
//   5-7           read 0, writes ignored
//
// Ports:
//   clk   : clock, all state on the rising edge
//   rstn  : synchronous active-low reset
//   pins  : asynchronous pin levels, WIDTH bits
//   addr  : register word address
//   we    : write strobe, one cycle per write
//   re    : read strobe
//   wdata : write data
//   rdata : registered read data
//   irq   : level interrupt, OR of PENDING & IRQ_EN
// ---------------------------------------------------------------------------
module gpio_irq_ctrl
  import gpio_irq_ctrl_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int STAGES          = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] pins,
  input  logic [2:0]       addr,
  input  logic             we,
  input  logic             re,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  logic [WIDTH-1:0] irq_en_q,  irq_en_d;
  logic [WIDTH-1:0] pend_q,    pend_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] rdata_q,   rdata_d;
  logic [WIDTH-1:0] pend_set;
  logic [WIDTH-1:0] pend_clr;
  logic [WIDTH-1:0] rd_val;

  synchronizer #(
    .LEN    (WIDTH),
    .STAGES (STAGES)
  ) u_sync (
    .clk_i (clk),
    .d_i   (pins),
    .q_o   (sync)
  );

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cell (
      .clk_i  (clk),
      .rstn_i (rstn),
      .s_i    (sync[g]),
      .v_o    (state[g]),
      .rise_o (rise[g]),
      .fall_o (fall[g])
    );
  end

  // Register next-state. PENDING clears by W1C and then ORs in new events, so
  // an event landing in the same cycle as a clear is never lost. The read mux
  // looks at the current register values, so a read that coincides with a
  // write returns the old contents.
  always_comb begin
    irq_en_d  = irq_en_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    rdata_d   = rdata_q;
    pend_set  = (rise & rise_en_q) | (fall & fall_en_q);
    pend_clr  = (we && addr == ADDR_PENDING) ? wdata : '0;
    pend_d    = (pend_q & ~pend_clr) | pend_set;

    if (we) begin
      case (addr)
        ADDR_IRQ_EN:  irq_en_d  = wdata;
        ADDR_RISE_EN: rise_en_d = wdata;
        ADDR_FALL_EN: fall_en_d = wdata;
        default: ;
      endcase
    end

    case (addr)
      ADDR_STATE:   rd_val = state;
      ADDR_IRQ_EN:  rd_val = irq_en_q;
      ADDR_PENDING: rd_val = pend_q;
      ADDR_RISE_EN: rd_val = rise_en_q;
      ADDR_FALL_EN: rd_val = fall_en_q;
      default:      rd_val = '0;
    endcase

    if (re) begin
      rdata_d = rd_val;
    end
  end

  // Register state with synchronous reset to an all-quiet configuration.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      irq_en_q  <= '0;
      pend_q    <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      rdata_q   <= '0;
    end else begin
      irq_en_q  <= irq_en_d;
      pend_q    <= pend_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      rdata_q   <= rdata_d;
    end
  end

  assign rdata = rdata_q;
  assign irq   = |(pend_q & irq_en_q);

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gpio_irq_ctrl
// Directed bench for gpio_irq_ctrl (WIDTH=8, STAGES=2, DEBOUNCE_CYCLES=4).
// Stimulus drives inputs just after each falling edge and queues the
// expected read data / irq level; a monitor compares on the next falling
// edge after the rising edge that consumed the strobe.
// ---------------------------------------------------------------------------
module tb_gpio_irq_ctrl;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;
  localparam int DEB    = 4;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [WIDTH-1:0] pins = '0;
  logic [2:0]       addr = '0;
  logic             we = 1'b0;
  logic             re = 1'b0;
  logic [WIDTH-1:0] wdata = '0;
  logic [WIDTH-1:0] rdata;
  logic             irq;

  logic irqProbe = 1'b0;
  logic rdValid  = 1'b0;
  logic irqValid = 1'b0;

  int checks = 0;
  int errors = 0;

  string      rdNameQ[$];
  logic [7:0] rdExpQ[$];
  string      irqNameQ[$];
  logic       irqExpQ[$];

  gpio_irq_ctrl #(
    .WIDTH           (WIDTH),
    .STAGES          (STAGES),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .pins  (pins),
    .addr  (addr),
    .we    (we),
    .re    (re),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
    end
  endtask

  // Marks which edges carried a read or irq probe, so the monitor knows when
  // the DUT has an answer worth comparing.
  always @(posedge clk) begin
    rdValid  <= re;
    irqValid <= irqProbe;
  end

  // Monitor: pops the oldest expectation for each output that was strobed
  // and compares it against what the DUT now presents.
  always @(negedge clk) begin
    if (rdValid) begin
      if (rdExpQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL read-queue: got read 0x%02h, expected no read", rdata);
      end else begin
        checkOutput(rdNameQ.pop_front(), rdata, rdExpQ.pop_front());
      end
    end
    if (irqValid) begin
      if (irqExpQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL irq-queue: got irq %0b, expected no probe", irq);
      end else begin
        checkOutput(irqNameQ.pop_front(), {7'b0, irq}, {7'b0, irqExpQ.pop_front()});
      end
    end
  end

  // Each step consumes exactly one rising edge and clears the strobes.
  task automatic step();
    @(negedge clk);
    we       = 1'b0;
    re       = 1'b0;
    irqProbe = 1'b0;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic applyStimulus(input logic [2:0] a, input logic [7:0] d);
    we    = 1'b1;
    addr  = a;
    wdata = d;
  endtask

  task automatic writeReg(input logic [2:0] a, input logic [7:0] d);
    applyStimulus(a, d);
    step();
  endtask

  task automatic expectRead(input logic [2:0] a, input logic [7:0] exp, input string name);
    re   = 1'b1;
    addr = a;
    rdNameQ.push_back(name);
    rdExpQ.push_back(exp);
  endtask

  task automatic expectIrq(input logic exp, input string name);
    irqProbe = 1'b1;
    irqNameQ.push_back(name);
    irqExpQ.push_back(exp);
  endtask

  // Safety net so the run always ends with a summary.
  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected end of stimulus");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    $display("[TB] start");
    steps(4);
    rstn = 1'b1;

    // Reset state.
    expectRead(ADDR_STATE_TB(), 8'h00, "reset state"); expectIrq(1'b0, "reset irq"); step();
    expectRead(3'd1, 8'h00, "reset irq_en");  step();
    expectRead(3'd2, 8'h00, "reset pending"); step();
    expectRead(3'd3, 8'h00, "reset rise_en"); step();
    expectRead(3'd4, 8'h00, "reset fall_en"); step();

    // Three-cycle glitch on pin 1 with every edge enabled.
    writeReg(3'd3, 8'hFF);
    writeReg(3'd4, 8'hFF);
    writeReg(3'd1, 8'hFF);
    pins[1] = 1'b1;
    steps(3);
    pins[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      expectRead(3'd0, 8'h00, "glitch state");
      expectIrq(1'b0, "glitch irq");
      step();
    end
    expectRead(3'd2, 8'h00, "glitch pending"); step();

    // Clean rise on pin 0: lands on the 6th edge, not earlier.
    writeReg(3'd4, 8'h00);
    writeReg(3'd3, 8'h01);
    writeReg(3'd1, 8'h01);
    pins[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expectIrq(1'b0, "irq before 6th edge");
      step();
    end
    expectIrq(1'b1, "irq on 6th edge");
    expectRead(3'd0, 8'h00, "state before 6th edge");
    step();
    expectRead(3'd0, 8'h01, "state after rise"); step();
    expectRead(3'd2, 8'h01, "pending after rise"); step();
    writeReg(3'd6, 8'hFF);
    expectRead(3'd6, 8'h00, "unmapped addr"); step();

    // W1C clears, then a clear colliding with a new rise event loses.
    applyStimulus(3'd2, 8'h01);
    expectIrq(1'b0, "irq after w1c");
    step();
    expectRead(3'd2, 8'h00, "pending after w1c"); step();
    pins[0] = 1'b0;
    steps(8);
    pins[0] = 1'b1;
    steps(5);
    applyStimulus(3'd2, 8'h01);
    expectIrq(1'b1, "irq set beats w1c");
    step();
    expectRead(3'd2, 8'h01, "pending set beats w1c"); step();
    writeReg(3'd2, 8'h01);

    // Falling edge on pin 7 latched while masked, then unmasked.
    writeReg(3'd3, 8'h00);
    writeReg(3'd4, 8'h80);
    writeReg(3'd1, 8'h00);
    pins[7] = 1'b1;
    steps(8);
    expectRead(3'd2, 8'h00, "pending rise without rise_en"); step();
    pins[7] = 1'b0;
    steps(8);
    expectRead(3'd2, 8'h80, "pending fall"); expectIrq(1'b0, "irq masked"); step();
    applyStimulus(3'd1, 8'h80);
    expectRead(3'd1, 8'h00, "read before same-cycle write");
    expectIrq(1'b1, "irq after enable");
    step();
    expectRead(3'd1, 8'h80, "irq_en readback"); step();
    expectRead(3'd0, 8'h01, "state pin0 only"); step();
    writeReg(3'd2, 8'h80);

    // All pins held high through reset; rise_en is zero afterwards.
    pins = 8'hFF;
    rstn = 1'b0;
    steps(3);
    rstn = 1'b1;
    steps(3);
    expectRead(3'd0, 8'h00, "state before post-reset debounce"); step();
    expectRead(3'd0, 8'hFF, "state held high through reset"); step();
    expectRead(3'd2, 8'h00, "pending after held-high release");
    expectIrq(1'b0, "irq after held-high release");
    step();

    // Reset in the middle of a pin-2 debounce discards the count.
    writeReg(3'd4, 8'hFF);
    writeReg(3'd1, 8'hFF);
    writeReg(3'd3, 8'h04);
    pins = 8'h00;
    steps(8);
    expectRead(3'd2, 8'hFF, "pending all fall"); expectIrq(1'b1, "irq all fall"); step();
    pins = 8'h04;
    steps(4);
    rstn = 1'b0;
    expectIrq(1'b0, "irq in reset");
    step();
    rstn = 1'b1;
    expectRead(3'd1, 8'h00, "irq_en after reset"); step();
    expectRead(3'd2, 8'h00, "pending after reset"); expectIrq(1'b0, "irq after reset"); step();
    expectRead(3'd3, 8'h00, "rise_en after reset"); step();
    expectRead(3'd0, 8'h00, "state count restarted"); step();
    expectRead(3'd0, 8'h04, "state after restart"); step();
    expectRead(3'd4, 8'h00, "fall_en after reset"); step();
    expectRead(3'd2, 8'h00, "pending after restart"); step();

    steps(2);
    checkOutput("leftover expectations", 8'(rdExpQ.size() + irqExpQ.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  function automatic logic [2:0] ADDR_STATE_TB();
    return 3'd0;
  endfunction

endmodule
